// File: rtl/bit_timing_ctrl.sv
// ---------------------------------------------------------------------------
// bit_timing_ctrl
//
// CAN bit-timing controller. Each nominal bit is sequenced as SYNC (1 tq),
// SEG1 (tseg1+1 tq, lengthened by late-edge resync) and SEG2 (tseg2+1 tq,
// shortened by early-edge resync). Generates the sample-point strobe, the
// sampled bit value and the transmit-point strobe (start of each bit).
//
// Optional build macro:
//   BIT_TIMING_TRIPLE_SAMPLE_EN - rx_bit_o is the majority of the three last
//   SEG1 quanta (single sampling when SEG1 is shorter than 3 tq). Without it,
//   rx_bit_o is rx_i taken at the last SEG1 quantum.
//
// Ports:
//   clock_i        system clock
//   reset_i        asynchronous active-high reset
//   enable_i       0 holds the block idle in SYNC (rx_bit_o holds)
//   tq_en_i        one-clock strobe per time quantum
//   rx_i           synchronised bus level
//   edge_i         one-clock strobe on a recessive-to-dominant edge
//   hsync_en_i     1 = an edge causes a hard sync
//   tseg1_i        SEG1 length minus 1
//   tseg2_i        SEG2 length minus 1
//   sjw_i          SJW minus 1
//   sample_pulse_o one clock at the sample point
//   rx_bit_o       sampled bit value
//   tx_point_o     one clock at the start of each bit
//   seg_state_o    00 SYNC, 01 SEG1, 10 SEG2
//   resync_o       one clock when a resync or hard sync is applied
// ---------------------------------------------------------------------------
module bit_timing_ctrl #(
    parameter int unsigned CNT_W   = 5,
    parameter logic        RX_IDLE = 1'b1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       tq_en_i,
    input  logic       rx_i,
    input  logic       edge_i,
    input  logic       hsync_en_i,
    input  logic [2:0] tseg1_i,
    input  logic [2:0] tseg2_i,
    input  logic [1:0] sjw_i,
    output logic       sample_pulse_o,
    output logic       rx_bit_o,
    output logic       tx_point_o,
    output logic [1:0] seg_state_o,
    output logic       resync_o
);

    localparam logic [1:0] ST_SYNC = 2'b00;
    localparam logic [1:0] ST_SEG1 = 2'b01;
    localparam logic [1:0] ST_SEG2 = 2'b10;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] THREE = CNT_W'(3);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ext_q, ext_d;
    logic [CNT_W-1:0] short_q, short_d;
    logic             edge_used_q, edge_used_d;
    logic             sample_pulse_q, sample_pulse_d;
    logic             tx_point_q, tx_point_d;
    logic             resync_q, resync_d;
    logic             rx_bit_q, rx_bit_d;
`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
    // hist_q[0] = rx at the previous SEG1 quantum, hist_q[1] = the one before
    logic [1:0]       hist_q, hist_d;
`endif

    logic [CNT_W-1:0] l1, l2, sjw_v;
    logic [CNT_W-1:0] l1eff, l2eff;
    logic [CNT_W-1:0] err;
    logic             restart;
    logic             sample_val;

    always_comb begin
        l1    = {{(CNT_W-3){1'b0}}, tseg1_i} + ONE;
        l2    = {{(CNT_W-3){1'b0}}, tseg2_i} + ONE;
        sjw_v = {{(CNT_W-2){1'b0}}, sjw_i} + ONE;

        state_d        = state_q;
        cnt_d          = cnt_q;
        ext_d          = ext_q;
        short_d        = short_q;
        edge_used_d    = edge_used_q;
        sample_pulse_d = 1'b0;
        tx_point_d     = 1'b0;
        resync_d       = 1'b0;
        rx_bit_d       = rx_bit_q;
`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
        hist_d         = hist_q;
`endif
        err     = '0;
        restart = 1'b0;

        // Edge evaluation uses the current state/cnt; its ext/short update is
        // seen by the tq_en transition below in the same clock.
        if (enable_i && edge_i && !edge_used_q) begin
            edge_used_d = 1'b1;
            if (hsync_en_i) begin
                restart = 1'b1;
            end else begin
                case (state_q)
                    ST_SEG1: begin
                        // late edge: phase error = quanta already spent in SEG1
                        resync_d = 1'b1;
                        err      = cnt_q + ONE;
                        ext_d    = (err < sjw_v) ? err : sjw_v;
                    end
                    ST_SEG2: begin
                        // early edge: phase error = quanta left until nominal SYNC
                        resync_d = 1'b1;
                        err      = l2 - cnt_q;
                        if (err <= sjw_v) begin
                            restart = 1'b1;
                        end else begin
                            short_d = sjw_v;
                        end
                    end
                    default: begin
                        // edge in SYNC: zero phase error, only consumes the edge
                    end
                endcase
            end
        end

        l1eff = l1 + ext_d;
        l2eff = l2 - short_d;

`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
        if (l1eff >= THREE) begin
            sample_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_i) | (hist_q[0] & rx_i);
        end else begin
            sample_val = rx_i;
        end
`else
        sample_val = rx_i;
`endif

        if (!enable_i) begin
            state_d     = ST_SYNC;
            cnt_d       = '0;
            ext_d       = '0;
            short_d     = '0;
            edge_used_d = 1'b0;
        end else if (restart) begin
            // the edge quantum stands in for SYNC; a coincident tq_en is consumed
            state_d    = ST_SEG1;
            cnt_d      = '0;
            ext_d      = '0;
            short_d    = '0;
            tx_point_d = 1'b1;
            resync_d   = 1'b1;
        end else if (tq_en_i) begin
            case (state_q)
                ST_SYNC: begin
                    state_d = ST_SEG1;
                    cnt_d   = '0;
                end
                ST_SEG1: begin
`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
                    hist_d = {hist_q[0], rx_i};
`endif
                    if (cnt_q == l1eff - ONE) begin
                        state_d        = ST_SEG2;
                        cnt_d          = '0;
                        sample_pulse_d = 1'b1;
                        edge_used_d    = 1'b0;
                        rx_bit_d       = sample_val;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                ST_SEG2: begin
                    if (cnt_q == l2eff - ONE) begin
                        state_d    = ST_SYNC;
                        cnt_d      = '0;
                        ext_d      = '0;
                        short_d    = '0;
                        tx_point_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= ST_SYNC;
            cnt_q          <= '0;
            ext_q          <= '0;
            short_q        <= '0;
            edge_used_q    <= 1'b0;
            sample_pulse_q <= 1'b0;
            tx_point_q     <= 1'b0;
            resync_q       <= 1'b0;
            rx_bit_q       <= RX_IDLE;
`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
            hist_q         <= {RX_IDLE, RX_IDLE};
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ext_q          <= ext_d;
            short_q        <= short_d;
            edge_used_q    <= edge_used_d;
            sample_pulse_q <= sample_pulse_d;
            tx_point_q     <= tx_point_d;
            resync_q       <= resync_d;
            rx_bit_q       <= rx_bit_d;
`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
            hist_q         <= hist_d;
`endif
        end
    end

    assign sample_pulse_o = sample_pulse_q;
    assign rx_bit_o       = rx_bit_q;
    assign tx_point_o     = tx_point_q;
    assign seg_state_o    = state_q;
    assign resync_o       = resync_q;

endmodule

// File: tb/tb_bit_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bit_timing_ctrl
//
// Bench for bit_timing_ctrl. A position-in-bit model (quantum index since
// the bit start plus current segment lengths) predicts every output each
// clock; directed bits pin bit lengths, sample offset and rx_bit by hand.
// ---------------------------------------------------------------------------
module tb_bit_timing_ctrl;

    localparam logic RX_IDLE = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       tq  = 1'b0;
    logic       rx  = 1'b1;
    logic       edg = 1'b0;
    logic       hs  = 1'b0;
    logic [2:0] t1  = 3'd3;
    logic [2:0] t2  = 3'd2;
    logic [1:0] sj  = 2'd0;

    logic       sp, rxb, txp, rs;
    logic [1:0] seg;

    bit_timing_ctrl #(.CNT_W(5), .RX_IDLE(RX_IDLE)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .tq_en_i       (tq),
        .rx_i          (rx),
        .edge_i        (edg),
        .hsync_en_i    (hs),
        .tseg1_i       (t1),
        .tseg2_i       (t2),
        .sjw_i         (sj),
        .sample_pulse_o(sp),
        .rx_bit_o      (rxb),
        .tx_point_o    (txp),
        .seg_state_o   (seg),
        .resync_o      (rs)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pos = quantum index inside the bit: 0 = SYNC, 1..L1+add1 = SEG1,
    // beyond that SEG2 up to L1+add1+L2-cut2.
    int  pos = 0, add1 = 0, cut2 = 0, L1, L2, SJ, e;
    bit  used = 0, restart;
    bit  m_sp = 0, m_tx = 0, m_rs = 0, m_rxb = RX_IDLE;
    bit  [1:0] m_seg = 2'd0;
    bit  samp [0:15];

    always @(posedge clk or posedge rst) begin
        L1 = int'(t1) + 1;
        L2 = int'(t2) + 1;
        SJ = int'(sj) + 1;
        if (rst) begin
            pos = 0; add1 = 0; cut2 = 0; used = 0;
            m_sp = 0; m_tx = 0; m_rs = 0; m_rxb = RX_IDLE;
        end else begin
            m_sp = 0; m_tx = 0; m_rs = 0;
            if (!en) begin
                pos = 0; add1 = 0; cut2 = 0; used = 0;
            end else begin
                restart = 0;
                if (edg && !used) begin
                    used = 1;
                    if (hs) restart = 1;
                    else if (pos >= 1 && pos <= L1 + add1) begin
                        m_rs = 1;
                        add1 = (pos < SJ) ? pos : SJ;
                    end else if (pos > L1 + add1) begin
                        m_rs = 1;
                        e = L2 - (pos - 1 - L1 - add1);
                        if (e <= SJ) restart = 1;
                        else cut2 = SJ;
                    end
                end
                if (restart) begin
                    pos = 1; add1 = 0; cut2 = 0; m_tx = 1; m_rs = 1;
                end else if (tq) begin
                    if (pos >= 1 && pos <= L1 + add1) samp[pos] = rx;
                    if (pos == L1 + add1) begin
                        m_sp = 1;
                        used = 0;
`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
                        if (pos >= 3)
                            m_rxb = (int'(samp[pos-2]) + int'(samp[pos-1]) + int'(samp[pos])) >= 2;
                        else
                            m_rxb = samp[pos];
`else
                        m_rxb = samp[pos];
`endif
                    end
                    if (pos == L1 + add1 + L2 - cut2) begin
                        pos = 0; add1 = 0; cut2 = 0; m_tx = 1;
                    end else begin
                        pos++;
                    end
                end
            end
        end
        m_seg = (pos == 0) ? 2'd0 : (pos <= L1 + add1) ? 2'd1 : 2'd2;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            cmp("sample_pulse", int'(sp),  int'(m_sp));
            cmp("tx_point",     int'(txp), int'(m_tx));
            cmp("resync",       int'(rs),  int'(m_rs));
            cmp("seg_state",    int'(seg), int'(m_seg));
            cmp("rx_bit",       int'(rxb), int'(m_rxb));
        end
    end

    // ---------------- directed helpers ----------------
    int seg_log [0:63];

    // Starts at a tx_point negedge (or anywhere, to align) and runs until the
    // next tx_point. Edge/rx for the quantum after negedge n come from bit n.
    task automatic bit_len(input logic [31:0] emask, input logic [31:0] rmask,
                           output int n, output int nrs, output int sp_at, output int seg_tx);
        n = 0; nrs = 0; sp_at = -1; seg_tx = -1;
        seg_log[0] = int'(seg);
        edg = emask[0];
        rx  = rmask[0];
        forever begin
            @(negedge clk);
            n++;
            if (n < 64) seg_log[n] = int'(seg);
            if (txp) begin
                seg_tx = int'(seg);
                break;
            end
            if (rs) nrs++;
            if (sp && sp_at < 0) sp_at = n;
            if (n > 60) begin
                total++; bad++;
                $display("FAIL bit_len: no tx_point after %0d clocks (expected within 60)", n);
                break;
            end
            edg = (n < 32) ? emask[n] : 1'b0;
            rx  = (n < 32) ? rmask[n] : 1'b1;
        end
        edg = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] a, input logic [2:0] b, input logic [1:0] c);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        t1 = a; t2 = b; sj = c;
        en = 1'b1;
    endtask

    int n, nrs, spa, sgt, cntp;
    int nom_seq [0:7] = '{0, 1, 1, 1, 1, 2, 2, 2};

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        cmp("reset_sample_pulse", int'(sp),  0);
        cmp("reset_tx_point",     int'(txp), 0);
        cmp("reset_resync",       int'(rs),  0);
        cmp("reset_seg_state",    int'(seg), 0);
        cmp("reset_rx_bit",       int'(rxb), 1);
        #2 rst = 1'b0;
        cmp_on = 1'b1;
        tq = 1'b1;

        // nominal: 1 + 4 + 3 tq
        cfg(3'd3, 3'd2, 2'd0);
        bit_len(32'h0, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        bit_len(32'h0, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("nominal_len", n, 8);
        cmp("nominal_sample_at", spa, 5);
        cmp("nominal_resyncs", nrs, 0);
        for (int i = 0; i < 8; i++) cmp("nominal_seg_seq", seg_log[i], nom_seq[i]);

        // late edge at SEG1 cnt=1, SJW=1
        bit_len(32'h4, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("late_sjw1_len", n, 9);
        cmp("late_sjw1_resyncs", nrs, 1);
        bit_len(32'h0, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("after_late_len", n, 8);

        // second edge in same SEG1 is ignored
        bit_len(32'hC, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("second_edge_len", n, 9);
        cmp("second_edge_resyncs", nrs, 1);

        // edge after the sample point is acted on (early, SJW=1 -> short)
        bit_len(32'h44, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("edge_after_sample_len", n, 8);
        cmp("edge_after_sample_resyncs", nrs, 2);

        // early edge at SEG2 cnt=0, SJW=1 -> 7 tq
        bit_len(32'h20, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("early_sjw1_len", n, 7);
        cmp("early_sjw1_resyncs", nrs, 1);

        // SJW=4
        cfg(3'd3, 3'd2, 2'd3);
        bit_len(32'h0, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        bit_len(32'h4, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("late_sjw4_len", n, 10);
        bit_len(32'h0, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("after_late4_len", n, 8);
        bit_len(32'h20, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("early_restart_len", n, 6);
        cmp("early_restart_seg", sgt, 1);
        bit_len(32'h0, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("after_restart_len", n, 7);

        // hard sync at SEG2 cnt=1
        hs = 1'b1;
        bit_len(32'h40, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        hs = 1'b0;
        cmp("hsync_len", n, 7);
        cmp("hsync_seg", sgt, 1);
        bit_len(32'h0, 32'hFFFF_FFFF, n, nrs, spa, sgt);
        cmp("after_hsync_len", n, 7);

        // rx sampling
        bit_len(32'h0, 32'h0, n, nrs, spa, sgt);
        cmp("rx_all_zero", int'(rxb), 0);
        bit_len(32'h0, 32'hFFFF_FFF3, n, nrs, spa, sgt);
`ifdef BIT_TIMING_TRIPLE_SAMPLE_EN
        cmp("rx_pattern_001", int'(rxb), 0);
`else
        cmp("rx_pattern_001", int'(rxb), 1);
`endif
        bit_len(32'h0, 32'h0, n, nrs, spa, sgt);
        cmp("rx_zero_again", int'(rxb), 0);

        // reset mid-SEG1
        repeat (2) @(negedge clk);
        cmp("pre_reset_seg", int'(seg), 1);
        #2 rst = 1'b1;
        #1;
        cmp("midreset_seg_state", int'(seg), 0);
        cmp("midreset_rx_bit",    int'(rxb), 1);
        cmp("midreset_tx_point",  int'(txp), 0);
        cmp("midreset_sample",    int'(sp),  0);
        cmp("midreset_resync",    int'(rs),  0);
        @(negedge clk);
        #2 rst = 1'b0;

        // enable low: no pulses, stays in SYNC
        @(negedge clk);
        en = 1'b0;
        cntp = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0 && (sp || txp || rs || seg != 2'd0)) cntp++;
            edg = 1'($urandom_range(0, 1));
            hs  = 1'($urandom_range(0, 1));
        end
        cmp("disabled_activity", cntp, 0);
        edg = 1'b0; hs = 1'b0;

        // randomized phases against the model
        for (int p = 0; p < 40; p++) begin
            @(negedge clk);
            en = 1'b0;
            edg = 1'b0;
            t1 = 3'($urandom_range(0, 7));
            t2 = 3'($urandom_range(0, 7));
            sj = 2'($urandom_range(0, 3));
            @(negedge clk);
            en = 1'b1;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                tq  = ($urandom_range(0, 3) != 0);
                edg = ($urandom_range(0, 7) == 0);
                hs  = ($urandom_range(0, 5) == 0);
                rx  = 1'($urandom_range(0, 1));
                en  = ($urandom_range(0, 99) != 0);
                if ($urandom_range(0, 299) == 0) begin
                    #2 rst = 1'b1;
                    @(negedge clk);
                    #2 rst = 1'b0;
                end
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
